// File: rtl/mcp_controller.sv
// mcp_controller: multicycle MIPS control unit (Moore main FSM, ALU decoder, PC enable)
module mcp_controller (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       pcen,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regwrite,
   output logic       alusrca,
   output logic       iord,
   output logic       memtoreg,
   output logic       regdst,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [2:0] alucontrol
);
   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      EXECUTE = 4'd6,
      ALUWB   = 4'd7,
      BRANCH  = 4'd8,
      ADDIEX  = 4'd9,
      ADDIWB  = 4'd10,
      JUMP    = 4'd11
   } state_t;
   localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_R = 6'b000000,
                          OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
   state_t state, state_n;
   logic       pcwrite, branch;
   logic [1:0] aluop;
   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= FETCH;
      else        state <= state_n;
   always_comb begin
      state_n  = FETCH;
      pcwrite  = 1'b0;
      branch   = 1'b0;
      memwrite = 1'b0;
      irwrite  = 1'b0;
      regwrite = 1'b0;
      alusrca  = 1'b0;
      iord     = 1'b0;
      memtoreg = 1'b0;
      regdst   = 1'b0;
      alusrcb  = 2'b00;
      pcsrc    = 2'b00;
      aluop    = 2'b00;
      case (state)
         FETCH: begin
            state_n = DECODE;
            irwrite = 1'b1;
            pcwrite = 1'b1;
            alusrcb = 2'b01;
         end
         DECODE: begin
            state_n = (op == OP_LW || op == OP_SW) ? MEMADR :
                      (op == OP_R)    ? EXECUTE :
                      (op == OP_BEQ)  ? BRANCH  :
                      (op == OP_ADDI) ? ADDIEX  :
                      (op == OP_J)    ? JUMP    : FETCH;
            alusrcb = 2'b11;
         end
         MEMADR: begin
            state_n = (op == OP_LW) ? MEMRD : MEMWR;
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         MEMRD: begin
            state_n = MEMWB;
            iord    = 1'b1;
         end
         MEMWB: begin
            regwrite = 1'b1;
            memtoreg = 1'b1;
         end
         MEMWR: begin
            iord     = 1'b1;
            memwrite = 1'b1;
         end
         EXECUTE: begin
            state_n = ALUWB;
            alusrca = 1'b1;
            aluop   = 2'b10;
         end
         ALUWB: begin
            regwrite = 1'b1;
            regdst   = 1'b1;
         end
         BRANCH: begin
            alusrca = 1'b1;
            aluop   = 2'b01;
            pcsrc   = 2'b01;
            branch  = 1'b1;
         end
         ADDIEX: begin
            state_n = ADDIWB;
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         ADDIWB: regwrite = 1'b1;
         JUMP: begin
            pcsrc   = 2'b10;
            pcwrite = 1'b1;
         end
         default: state_n = FETCH;
      endcase
   end
   always_comb
      alucontrol = (aluop == 2'b01) ? 3'b110 :
                   (aluop != 2'b10) ? 3'b010 :
                   (funct == 6'b100000) ? 3'b010 :
                   (funct == 6'b100010) ? 3'b110 :
                   (funct == 6'b100100) ? 3'b000 :
                   (funct == 6'b100101) ? 3'b001 :
                   (funct == 6'b101010) ? 3'b111 : 3'b000;
   assign pcen = pcwrite | (branch & zero);
endmodule

// File: tb/tb_mcp_controller.sv
// tb_mcp_controller: table-driven scoreboard bench for mcp_controller
module tb_mcp_controller;
   logic       clk, reset, zero;
   logic [5:0] op, funct;
   logic       pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst;
   logic [1:0] alusrcb, pcsrc;
   logic [2:0] alucontrol;
   logic [14:0] got;
   int tests = 0, fails = 0;

   mcp_controller dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
      .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
      .alusrca(alusrca), .iord(iord), .memtoreg(memtoreg), .regdst(regdst),
      .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol)
   );

   assign got = {pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst,
                 alusrcb, pcsrc, alucontrol};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string            name;
      logic [5:0]       op;
      logic [5:0]       funct;
      logic             zero;
      int               n;
      logic [4:0][14:0] exp;
   } vec_t;

   vec_t vecs[14];
   logic [14:0] sb[$];

   task automatic chk(input string name, input logic [14:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%04h expected 0x%04h", name, got, exp);
      end
   endtask

   initial begin
      vecs[0]  = '{"lw",     6'b100011, 6'b000000, 1'b0, 5, {15'h0902, 15'h0202, 15'h0442, 15'h0062, 15'h5022}};
      vecs[1]  = '{"sw",     6'b101011, 6'b000000, 1'b0, 4, {15'h0000, 15'h2202, 15'h0442, 15'h0062, 15'h5022}};
      vecs[2]  = '{"r_add",  6'b000000, 6'b100000, 1'b0, 4, {15'h0000, 15'h0882, 15'h0402, 15'h0062, 15'h5022}};
      vecs[3]  = '{"r_sub",  6'b000000, 6'b100010, 1'b0, 4, {15'h0000, 15'h0882, 15'h0406, 15'h0062, 15'h5022}};
      vecs[4]  = '{"r_and",  6'b000000, 6'b100100, 1'b1, 4, {15'h0000, 15'h0882, 15'h0400, 15'h0062, 15'h5022}};
      vecs[5]  = '{"r_or",   6'b000000, 6'b100101, 1'b0, 4, {15'h0000, 15'h0882, 15'h0401, 15'h0062, 15'h5022}};
      vecs[6]  = '{"r_slt",  6'b000000, 6'b101010, 1'b0, 4, {15'h0000, 15'h0882, 15'h0407, 15'h0062, 15'h5022}};
      vecs[7]  = '{"r_unk",  6'b000000, 6'b111111, 1'b0, 4, {15'h0000, 15'h0882, 15'h0400, 15'h0062, 15'h5022}};
      vecs[8]  = '{"beq_t",  6'b000100, 6'b100101, 1'b1, 3, {15'h0000, 15'h0000, 15'h440E, 15'h0062, 15'h5022}};
      vecs[9]  = '{"beq_nt", 6'b000100, 6'b000000, 1'b0, 3, {15'h0000, 15'h0000, 15'h040E, 15'h0062, 15'h5022}};
      vecs[10] = '{"addi",   6'b001000, 6'b101010, 1'b1, 4, {15'h0000, 15'h0802, 15'h0442, 15'h0062, 15'h5022}};
      vecs[11] = '{"j",      6'b000010, 6'b000000, 1'b0, 3, {15'h0000, 15'h0000, 15'h4012, 15'h0062, 15'h5022}};
      vecs[12] = '{"unk_op", 6'b111111, 6'b100000, 1'b0, 2, {15'h0000, 15'h0000, 15'h0000, 15'h0062, 15'h5022}};
      vecs[13] = '{"lw2",    6'b100011, 6'b100010, 1'b1, 5, {15'h0902, 15'h0202, 15'h0442, 15'h0062, 15'h5022}};

      reset = 1'b0; op = 6'b0; funct = 6'b0; zero = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_held", 15'h5022);
      reset = 1'b1;
      #1 chk("reset_released", 15'h5022);

      for (int v = 0; v < 14; v++) begin
         op = vecs[v].op; funct = vecs[v].funct; zero = vecs[v].zero;
         for (int c = 0; c < vecs[v].n; c++) sb.push_back(vecs[v].exp[c]);
         for (int c = 0; c < vecs[v].n; c++) begin
            #1 chk($sformatf("%s_c%0d", vecs[v].name, c), sb.pop_front());
            @(negedge clk);
         end
      end
      chk("back_to_fetch", 15'h5022);

      op = 6'b000100; funct = 6'b0; zero = 1'b0;
      repeat (2) @(negedge clk);
      #1 chk("beq_z0", 15'h040E);
      zero = 1'b1;
      #1 chk("beq_z1_comb", 15'h440E);
      zero = 1'b0;
      #1 chk("beq_z0_comb", 15'h040E);
      @(negedge clk);
      #1 chk("beq_fetch", 15'h5022);

      op = 6'b100011;
      repeat (3) @(negedge clk);
      #1 chk("lw_memrd", 15'h0202);
      #1 reset = 1'b0;
      #1 chk("async_reset", 15'h5022);
      @(negedge clk);
      reset = 1'b1;
      #1 chk("after_reset_fetch", 15'h5022);
      @(negedge clk);
      #1 chk("after_reset_decode", 15'h0062);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/mcp_controller.md
Name: mcp_controller

Overview:
- Control unit of the multicycle MIPS processor (mcp datapath).
- A Moore main FSM sequences each instruction through fetch, decode and execute states.
- A combinational ALU decoder turns the FSM's internal 2-bit aluop plus the instruction funct field into the 3-bit ALU control.
- pcen combines the unconditional PC write with the branch-taken condition (zero flag).

Parameters:
- none

Ports:
- clk  in  1  system clock; state updates on rising edge
- reset  in  1  asynchronous, active-low (asserted when 0): forces state to FETCH immediately
- op  in  6  instruction opcode, instr[31:26]
- funct  in  6  instruction funct field, instr[5:0]
- zero  in  1  ALU zero flag
- pcen  out  1  PC register enable
- memwrite  out  1  memory write enable
- irwrite  out  1  instruction register write enable
- regwrite  out  1  register file write enable
- alusrca  out  1  ALU A select: 0=PC, 1=register A
- iord  out  1  memory address select: 0=PC, 1=ALUOut
- memtoreg  out  1  writeback select: 0=ALUOut, 1=Data register
- regdst  out  1  destination register select: 0=rt, 1=rd
- alusrcb  out  2  ALU B select: 00=B, 01=constant 4, 10=SignImm, 11=SignImm<<2
- pcsrc  out  2  next PC select: 00=ALUResult, 01=ALUOut, 10=jump target
- alucontrol  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt

Behaviour:
- Only clk and reset are sequential. Everything else is combinational from state, op, funct and zero.
- State register: 4 bits. Encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
- While reset is low, state is FETCH and outputs show FETCH values. The first rising edge after release moves to DECODE.
- Transitions:
  - FETCH->DECODE.
  - DECODE by op: 100011 lw / 101011 sw -> MEMADR; 000000 R-type -> EXECUTE; 000100 beq -> BRANCH; 001000 addi -> ADDIEX; 000010 j -> JUMP; any other op -> FETCH.
  - MEMADR: lw -> MEMRD, sw -> MEMWR.
  - MEMRD->MEMWB->FETCH.
  - MEMWR->FETCH.
  - EXECUTE->ALUWB->FETCH.
  - BRANCH->FETCH.
  - ADDIEX->ADDIWB->FETCH.
  - JUMP->FETCH.
  - Unused encodings 12-15 -> FETCH.
- Every output not listed for a state is 0, including alusrcb=00, pcsrc=00 and aluop=00.
- Per-state outputs:
  - FETCH: irwrite=1, pcwrite=1, alusrcb=01, aluop=00.
  - DECODE: alusrcb=11, aluop=00.
  - MEMADR: alusrca=1, alusrcb=10.
  - MEMRD: iord=1.
  - MEMWB: regwrite=1, memtoreg=1.
  - MEMWR: iord=1, memwrite=1.
  - EXECUTE: alusrca=1, aluop=10.
  - ALUWB: regwrite=1, regdst=1.
  - BRANCH: alusrca=1, aluop=01, pcsrc=01, branch=1.
  - ADDIEX: alusrca=1, alusrcb=10.
  - ADDIWB: regwrite=1.
  - JUMP: pcsrc=10, pcwrite=1.
- pcen = pcwrite | (branch & zero). It follows zero combinationally within the BRANCH state.
- ALU decoder (combinational, in every state):
  - aluop 00 -> 010.
  - aluop 01 -> 110.
  - aluop 10, decoded from funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111; any other funct -> 000.
  - aluop 11 -> 010.
- Instruction latencies in cycles including FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unknown op 2.

Test Plan:
- Reset low then release -> outputs packed {pcen,memwrite,irwrite,regwrite,alusrca,iord,memtoreg,regdst,alusrcb,pcsrc,alucontrol} = 0x5022 (FETCH). Next edge -> 0x0062 (DECODE).
- lw (op=100011) -> MEMADR then MEMRD then MEMWB (regwrite=1, memtoreg=1), then back to FETCH.
- sw (op=101011) -> MEMADR then MEMWR (iord=1, memwrite=1), then FETCH.
- R-type (op=000000), funct 100000/100010/100100/100101/101010 -> EXECUTE alucontrol 010/110/000/001/111, then ALUWB with regdst=1, regwrite=1.
- beq (op=000100) in BRANCH: zero=1 -> pcen=1, pcsrc=01, alucontrol=110; zero=0 -> pcen=0.
- addi -> ADDIEX (alusrcb=10) then ADDIWB (regwrite=1, regdst=0). j -> JUMP (pcen=1, pcsrc=10). Reset asserted mid-instruction -> FETCH outputs immediately, without waiting for a clock edge.
